// File: rtl/des_arb_pkg.sv
// des_arb_pkg: shared definitions for the DES core arbiter slice.
//   state_t  - arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   DES_W    - width of a DES block / key
//   DIR_ENC  - direction bit value selecting the encrypt core
//   DIR_DEC  - direction bit value selecting the decrypt core
package des_arb_pkg;

  localparam int DES_W = 64;

  localparam logic DIR_ENC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/des_core_arbiter_if.sv
// des_core_arbiter_if: requester-side and core-side buses of the arbiter.
//   Requester side: req_valid/req_ready/req_dir/req_data/req_key,
//                   rsp_valid/rsp_ready/rsp_data/rsp_err
//   Core side:      core_data/core_key, enc_data_vld/dec_data_vld,
//                   enc_result/enc_result_vld, dec_result/dec_result_vld
//   modport slave  - the arbiter's view
//   modport master - the environment's view (front ends plus DES cores)
interface des_core_arbiter_if #(
  parameter int NREQ = 2
);
  import des_arb_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_dir;
  logic [NREQ*DES_W-1:0] req_data;
  logic [NREQ*DES_W-1:0] req_key;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [DES_W-1:0]      rsp_data;
  logic                  rsp_err;
  logic [DES_W-1:0]      core_data;
  logic [DES_W-1:0]      core_key;
  logic                  enc_data_vld;
  logic                  dec_data_vld;
  logic [DES_W-1:0]      enc_result;
  logic                  enc_result_vld;
  logic [DES_W-1:0]      dec_result;
  logic                  dec_result_vld;

  modport slave (
    input  req_valid, req_dir, req_data, req_key, rsp_ready,
    input  enc_result, enc_result_vld, dec_result, dec_result_vld,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output core_data, core_key, enc_data_vld, dec_data_vld
  );

  modport master (
    output req_valid, req_dir, req_data, req_key, rsp_ready,
    output enc_result, enc_result_vld, dec_result, dec_result_vld,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  core_data, core_key, enc_data_vld, dec_data_vld
  );

endinterface

// File: rtl/des_core_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick among N requesters.
//   req       - request vector
//   ptr       - index where the search starts (highest priority)
//   grant     - one-hot winner
//   grant_idx - binary index of the winner
//   any       - at least one request is present
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW-1:0] idx;

  // Walk the offsets from farthest to nearest so that the last hit written
  // is the requester closest to ptr in circular order.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/des_core_arbiter.sv
// des_core_arbiter: shares one DES encrypt core and one DES decrypt core
// between NREQ requesters, one operation in flight at a time.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - des_core_arbiter_if.slave carrying the requester handshake
//              (req_*/rsp_*) and the core launch/result signals
// Parameters: NREQ (2..8) requesters, TIMEOUT cycles allowed in WAIT.
module des_core_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  des_core_arbiter_if.slave bus
);
  import des_arb_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t           state, state_d;
  logic [IW-1:0]    rr_ptr, rr_ptr_d;
  logic [IW-1:0]    owner, owner_d;
  logic [CW-1:0]    cnt, cnt_d, cnt_inc;
  logic [DES_W-1:0] data_q, data_d;
  logic [DES_W-1:0] key_q, key_d;
  logic             dir_q, dir_d;
  logic [DES_W-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    grant_idx;
  logic             any;
  logic             sel_vld;
  logic [DES_W-1:0] sel_res;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // Only the core chosen by the captured direction is listened to, so a
  // result pulse from the other core can never complete the operation.
  assign sel_vld = (dir_q == DIR_DEC) ? bus.dec_result_vld : bus.enc_result_vld;
  assign sel_res = (dir_q == DIR_DEC) ? bus.dec_result     : bus.enc_result;
  assign cnt_inc = cnt + CW'(1);

  assign bus.req_ready    = (state == IDLE) ? grant : '0;
  assign bus.rsp_valid    = (state == RESP) ? (NREQ'(1) << owner) : '0;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.core_data    = data_q;
  assign bus.core_key     = key_q;
  assign bus.enc_data_vld = (state == ISSUE) && (dir_q == DIR_ENC);
  assign bus.dec_data_vld = (state == ISSUE) && (dir_q == DIR_DEC);

  // State and datapath registers; reset drops any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      cnt        <= '0;
      data_q     <= '0;
      key_q      <= '0;
      dir_q      <= DIR_ENC;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_ptr_d;
      owner      <= owner_d;
      cnt        <= cnt_d;
      data_q     <= data_d;
      key_q      <= key_d;
      dir_q      <= dir_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state logic. The timeout fires on the WAIT cycle whose increment
  // brings the counter to TIMEOUT-1; a result seen on that same cycle is
  // tested first and therefore wins.
  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    owner_d    = owner;
    cnt_d      = cnt;
    data_d     = data_q;
    key_d      = key_q;
    dir_d      = dir_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state)
      IDLE: begin
        if (any) begin
          for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IW'(i)) begin
              data_d = bus.req_data[i*DES_W +: DES_W];
              key_d  = bus.req_key[i*DES_W +: DES_W];
            end
          end
          dir_d    = bus.req_dir[grant_idx];
          owner_d  = grant_idx;
          rr_ptr_d = IW'((int'(grant_idx) + 1) % NREQ);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (sel_vld) begin
          rsp_data_d = sel_res;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_inc == LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready[owner]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/des_core_arbiter.md
Name: des_core_arbiter

Overview:
Shares one DES encrypt core instance (DES_TYPE=0) and one decrypt core instance (DES_TYPE=1) between NREQ requesters. Arbitration is round-robin, and only one operation is in flight at a time.
Each requester issues a 64-bit block, a 64-bit key and a direction bit. The block launches the selected core with a single-cycle data_vld pulse, waits for that core's result_vld, and returns the result to the winning requester. A watchdog bounds the wait.
The block sits between the bus-side crypto front ends and the two DES core instances.

Parameters:
NREQ, 2, number of requesters (2..8)
TIMEOUT, 64, maximum cycles in WAIT before the operation is aborted with an error

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NREQ  request valid, one bit per requester
req_ready  out  NREQ  request accepted; at most one bit high
req_dir  in  NREQ  0 = encrypt, 1 = decrypt
req_data  in  NREQ*64  block per requester; slice i = [64*i +: 64]
req_key  in  NREQ*64  key per requester; same slicing
rsp_valid  out  NREQ  response valid for the owning requester
rsp_ready  in  NREQ  response accepted
rsp_data  out  64  result, shared by all requesters
rsp_err  out  1  timeout flag, qualified by rsp_valid
core_data  out  64  data bus to both cores
core_key  out  64  key bus to both cores
enc_data_vld  out  1  launch pulse to the encrypt core
dec_data_vld  out  1  launch pulse to the decrypt core
enc_result  in  64  encrypt core result
enc_result_vld  in  1  encrypt core result valid
dec_result  in  64  decrypt core result
dec_result_vld  in  1  decrypt core result valid

Behaviour:
- Reset values:
  - All outputs 0.
  - State = IDLE, rr_ptr = 0, wait counter = 0.
  - Reset mid-operation aborts the operation silently; no response is issued.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[g] is asserted combinationally in IDLE only.
  - On handshake at edge T: capture data, key, dir and g into registers; rr_ptr <= (g+1) mod NREQ; go to ISSUE.
  - With no request valid, stay in IDLE and leave rr_ptr unchanged.
- ISSUE, cycle T+1:
  - Drive core_data/core_key from the registers; pulse exactly one of enc_data_vld/dec_data_vld for one cycle, selected by dir.
  - Clear the counter; go to WAIT.
- core_data and core_key stay stable from ISSUE until return to IDLE.
- WAIT:
  - Count up each cycle. Only the selected core's result_vld is honoured.
  - Selected result_vld high: register that core's result into rsp_data, rsp_err <= 0, go to RESP.
  - Counter reaches TIMEOUT-1 with no result: rsp_data <= 0, rsp_err <= 1, go to RESP.
  - If result_vld and the timeout coincide, the result wins.
- Stray result_vld (non-selected core, or any core in IDLE, ISSUE or RESP) is ignored and has no side effect.
- RESP:
  - rsp_valid[g] = 1 and held, with rsp_data/rsp_err stable, until rsp_ready[g]=1; then go to IDLE.
  - A new grant is possible in the cycle after RESP exits.
- Latency: with core latency L (result_vld L cycles after data_vld), rsp_valid rises at T+L+2.
- Fairness: a continuously requesting requester waits for at most NREQ-1 other operations.

Decomposition:
- des_arb_pkg holds:
  - typedef enum state_t {IDLE, ISSUE, WAIT, RESP};
  - DES_W = 64;
  - DIR_ENC = 1'b0, DIR_DEC = 1'b1.
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; outputs grant one-hot, grant_idx and any.

Test Plan:
- Encrypt, requester 0: data 64'h636F6D7075746572, key 64'h133457799BBCDFF1, dir 0, real cores -> enc_data_vld single pulse, dec_data_vld stays 0; rsp_valid[0] with rsp_data 64'h5808300BCDD61868, rsp_err 0.
- Decrypt, requester 1: data 64'h5808300BCDD61868, same key, dir 1 -> dec_data_vld pulse only; rsp_valid[1] with rsp_data 64'h636F6D7075746572.
- Fairness: both requesters hold req_valid for 4 operations from reset -> grant order 0,1,0,1; rsp_valid is never high for the non-owner.
- Timeout: stub core never asserts result_vld, TIMEOUT=8 -> rsp_valid rises 8 cycles after ISSUE with rsp_err 1 and rsp_data 0.
- Backpressure and stray pulses:
  - Hold rsp_ready low 5 cycles -> rsp_valid/rsp_data stable, req_ready all 0.
  - Inject enc_result_vld during a decrypt WAIT -> ignored; the correct dec_result is returned.
- Reset in WAIT: assert rst mid-operation, then deliver a late result_vld after release -> no rsp_valid; outputs 0; the next request is granted to requester 0.
